// File: rtl/env_evaporator_if.sv
// rtl/env_evaporator_if.sv - deposit/sweep request and cell lookup/write bus for env_evaporator
interface env_evaporator_if #(
  parameter int X_bits      = 2,
  parameter int Y_bits      = 2,
  parameter int SIGNAL_bits = 4
);
  logic                   start_sweep;
  logic                   dep_valid;
  logic                   dep_ready;
  logic [X_bits-1:0]      dep_X;
  logic [Y_bits-1:0]      dep_Y;
  logic [SIGNAL_bits-1:0] dep_amount;
  logic                   dep_take_sugar;
  logic [X_bits-1:0]      lookup_X;
  logic [Y_bits-1:0]      lookup_Y;
  logic [SIGNAL_bits-1:0] lookup_signal;
  logic                   lookup_sugar;
  logic [X_bits-1:0]      write_X;
  logic [Y_bits-1:0]      write_Y;
  logic                   write_flag;
  logic [SIGNAL_bits-1:0] write_signal;
  logic                   write_sugar;
  logic                   busy;
  logic                   sweep_done;

  // environment side: issues requests, serves cell lookups, absorbs writes
  modport master (
    output start_sweep, dep_valid, dep_X, dep_Y, dep_amount, dep_take_sugar,
    output lookup_signal, lookup_sugar,
    input  dep_ready, lookup_X, lookup_Y,
    input  write_X, write_Y, write_flag, write_signal, write_sugar,
    input  busy, sweep_done
  );

  // evaporator side
  modport slave (
    input  start_sweep, dep_valid, dep_X, dep_Y, dep_amount, dep_take_sugar,
    input  lookup_signal, lookup_sugar,
    output dep_ready, lookup_X, lookup_Y,
    output write_X, write_Y, write_flag, write_signal, write_sugar,
    output busy, sweep_done
  );
endinterface

// File: rtl/env_evaporator.sv
// rtl/env_evaporator.sv - pheromone evaporation sweeper with interleaved deposit requests
module env_evaporator #(
  parameter int PIXELS_X    = 4,
  parameter int PIXELS_Y    = 3,
  parameter int X_bits      = 2,
  parameter int Y_bits      = 2,
  parameter int SIGNAL_bits = 4,
  parameter int DECAY       = 1
) (
  input  logic             newLocClock,
  input  logic             RESET_SIM,
  env_evaporator_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, SW_RD, SW_WR, DEP_RD, DEP_WR} state_t;

  localparam logic [X_bits-1:0]      X_LAST  = X_bits'(PIXELS_X - 1);
  localparam logic [Y_bits-1:0]      Y_LAST  = Y_bits'(PIXELS_Y - 1);
  localparam logic [SIGNAL_bits-1:0] DECAY_V = SIGNAL_bits'(DECAY);
  localparam logic [SIGNAL_bits-1:0] SIG_MAX = '1;

  state_t                 state, state_nx;
  logic [X_bits-1:0]      cur_x, adv_x, lk_x_nx;
  logic [Y_bits-1:0]      cur_y, adv_y, lk_y_nx;
  logic                   cur_last;
  logic                   hs;
  logic                   sweep_on, busy_nx;
  logic                   fin_pend, fin_nx;
  logic                   done_nx;
  logic [SIGNAL_bits-1:0] amt_q;
  logic                   take_q;
  logic [SIGNAL_bits:0]   dep_sum;
  logic [SIGNAL_bits-1:0] wr_sig_nx;
  logic                   wr_sug_nx;

  assign cur_last     = (cur_x == X_LAST) && (cur_y == Y_LAST);
  assign bus.dep_ready = !RESET_SIM && (state == IDLE || state == SW_WR);
  assign hs           = bus.dep_valid && bus.dep_ready;
  assign bus.busy     = sweep_on;

  // raster successor of the sweep cursor, wrapping to (0,0) after the last cell
  always_comb begin
    adv_x = cur_x + 1'b1;
    adv_y = cur_y;
    if (cur_x == X_LAST) begin
      adv_x = '0;
      adv_y = cur_last ? '0 : cur_y + 1'b1;
    end
  end

  // next state: deposits are only taken in IDLE and between sweep cells
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (hs) state_nx = DEP_RD;
               else if (bus.start_sweep) state_nx = SW_RD;
      SW_RD:   state_nx = SW_WR;
      SW_WR:   if (hs) state_nx = DEP_RD;
               else if (cur_last) state_nx = IDLE;
               else state_nx = SW_RD;
      DEP_RD:  state_nx = DEP_WR;
      DEP_WR:  state_nx = (sweep_on && !fin_pend) ? SW_RD : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // next values of the registered outputs and sweep bookkeeping
  always_comb begin
    lk_x_nx   = bus.lookup_X;
    lk_y_nx   = bus.lookup_Y;
    wr_sig_nx = bus.write_signal;
    wr_sug_nx = bus.write_sugar;
    dep_sum   = {1'b0, bus.lookup_signal} + {1'b0, amt_q};
    if (state_nx == DEP_RD) begin
      lk_x_nx = bus.dep_X;
      lk_y_nx = bus.dep_Y;
    end else if (state_nx == SW_RD) begin
      lk_x_nx = (state == SW_WR) ? adv_x : cur_x;
      lk_y_nx = (state == SW_WR) ? adv_y : cur_y;
    end
    case (state)
      SW_RD: begin
        wr_sig_nx = (bus.lookup_signal > DECAY_V) ? bus.lookup_signal - DECAY_V : '0;
        wr_sug_nx = bus.lookup_sugar;
      end
      DEP_RD: begin
        wr_sig_nx = dep_sum[SIGNAL_bits] ? SIG_MAX : dep_sum[SIGNAL_bits-1:0];
        wr_sug_nx = take_q ? 1'b0 : bus.lookup_sugar;
      end
      default: ;
    endcase
    done_nx = (state == SW_WR && cur_last && !hs) || (state == DEP_WR && fin_pend);
    busy_nx = sweep_on;
    if (state == IDLE && bus.start_sweep) busy_nx = 1'b1;
    if (done_nx) busy_nx = 1'b0;
    fin_nx = fin_pend;
    if (state == SW_WR && cur_last && hs) fin_nx = 1'b1;
    if (state == DEP_WR) fin_nx = 1'b0;
  end

  // state, cursor, latched deposit and registered outputs
  always_ff @(posedge newLocClock) begin
    if (RESET_SIM) begin
      state            <= IDLE;
      cur_x            <= '0;
      cur_y            <= '0;
      sweep_on         <= 1'b0;
      fin_pend         <= 1'b0;
      amt_q            <= '0;
      take_q           <= 1'b0;
      bus.lookup_X     <= '0;
      bus.lookup_Y     <= '0;
      bus.write_X      <= '0;
      bus.write_Y      <= '0;
      bus.write_flag   <= 1'b0;
      bus.write_signal <= '0;
      bus.write_sugar  <= 1'b0;
      bus.sweep_done   <= 1'b0;
    end else begin
      state            <= state_nx;
      sweep_on         <= busy_nx;
      fin_pend         <= fin_nx;
      bus.lookup_X     <= lk_x_nx;
      bus.lookup_Y     <= lk_y_nx;
      bus.write_flag   <= (state_nx == SW_WR) || (state_nx == DEP_WR);
      bus.write_signal <= wr_sig_nx;
      bus.write_sugar  <= wr_sug_nx;
      bus.sweep_done   <= done_nx;
      if (state == SW_RD || state == DEP_RD) begin
        bus.write_X <= bus.lookup_X;
        bus.write_Y <= bus.lookup_Y;
      end
      if (state == SW_WR) begin
        cur_x <= adv_x;
        cur_y <= adv_y;
      end
      if (hs) begin
        amt_q  <= bus.dep_amount;
        take_q <= bus.dep_take_sugar;
      end
    end
  end

endmodule

// File: doc/env_evaporator.md
ENV_EVAPORATOR -- requirements
Module: env_evaporator

Interface
REQ-001 SHALL have parameters (name, default, meaning): PIXELS_X, 4, grid width.
REQ-002 SHALL have PIXELS_Y, 3, grid height; X_bits, 2, and Y_bits, 2, cell coordinate widths.
REQ-003 SHALL have SIGNAL_bits, 4, pheromone width; DECAY, 1, amount subtracted per sweep.
REQ-004 SHALL use one clock and one reset: reset is synchronous and active-high.
REQ-005 newLocClock  in  1  clock; all state updates on its rising edge.
REQ-006 RESET_SIM  in  1  synchronous active-high reset.
REQ-007 start_sweep  in  1  request one full evaporation sweep.
REQ-008 dep_valid  in  1, dep_ready  out  1  deposit request handshake.
REQ-009 dep_X  in  X_bits, dep_Y  in  Y_bits, dep_amount  in  SIGNAL_bits, dep_take_sugar  in  1  deposit payload.
REQ-010 lookup_X  out  X_bits, lookup_Y  out  Y_bits, registered; lookup_signal  in  SIGNAL_bits, lookup_sugar  in  1, combinational from the environment.
REQ-011 write_X  out  X_bits, write_Y  out  Y_bits, write_flag  out  1, write_signal  out  SIGNAL_bits, write_sugar  out  1, all registered.
REQ-012 busy  out  1  sweep active or pending; sweep_done  out  1  one-cycle pulse.

Function
REQ-013 SHALL implement FSM states IDLE, SW_RD, SW_WR, DEP_RD, DEP_WR; every cell access is atomic: RD cycle (lookup address valid, captures lookup_signal/lookup_sugar) immediately followed by WR cycle (write_flag=1 exactly one cycle).
REQ-014 dep_ready SHALL be 1 only in IDLE and SW_WR with RESET_SIM low; handshake completes on dep_valid && dep_ready at a rising edge, latching the payload.
REQ-015 Accepted deposit: DEP_RD next cycle at (dep_X,dep_Y), DEP_WR the cycle after; write_signal = min(signal+dep_amount, 2^SIGNAL_bits-1), computed SIGNAL_bits+1 wide; write_sugar = dep_take_sugar ? 0 : captured sugar.
REQ-016 Sweep cell: write_signal = signal > DECAY ? signal-DECAY : 0; write_sugar = captured sugar unchanged.
REQ-017 Cursor SHALL scan raster order: X 0..PIXELS_X-1, then Y+1, starting at (0,0); wraps to (0,0) after (PIXELS_X-1,PIXELS_Y-1).
REQ-018 start_sweep in IDLE with dep_valid low: SW_RD at (0,0) next cycle; busy=1 from that cycle.
REQ-019 start_sweep and dep_valid both in IDLE: deposit served first, sweep pending latched (busy=1), sweep starts at (0,0) after DEP_WR.
REQ-020 start_sweep while busy SHALL be ignored.
REQ-021 From SW_WR: deposit accepted -> DEP_RD, then SW_RD at next cursor after DEP_WR; else SW_RD at next cursor; guarantees one sweep cell between consecutive deposits.
REQ-022 After the last cell's SW_WR (with no deposit accepted): sweep_done=1 for the next cycle, busy=0, state IDLE; if a deposit was accepted in that SW_WR, sweep_done pulses the cycle after its DEP_WR.
REQ-023 Sweep without deposits SHALL take exactly 2*PIXELS_X*PIXELS_Y cycles; each deposit adds exactly 2.
REQ-024 write_flag SHALL be 0 in all states except SW_WR and DEP_WR.

Reset
REQ-025 While RESET_SIM is high at an edge: state IDLE, cursor (0,0), pending cleared, all registered outputs 0 (lookup_X/Y, write_X/Y, write_flag, write_signal, write_sugar, busy, sweep_done); dep_ready 0.
REQ-026 Reset mid-sweep or mid-deposit SHALL abort: no further write_flag, no sweep_done pulse; the latched deposit is discarded.

Verification
REQ-027 Reset, all 12 cells signal 5, pulse start_sweep -> 12 write_flag pulses in raster order (0,0)..(3,2), every cell 4, sweep_done one cycle, 24 cycles after SW_RD entry.
REQ-028 Cells with signal 0 and 1, sweep -> both written 0; sugar bits unchanged.
REQ-029 IDLE, cell (2,1) signal 13 sugar 1, deposit amount 5 take_sugar 1 -> write (2,1) signal 15 sugar 0 two cycles after handshake; dep_ready low exactly 2 cycles.
REQ-030 dep_valid held high through a sweep of 12 cells -> writes alternate sweep cell/deposit, sweep completes in 48 cycles, cursor order intact.
REQ-031 start_sweep and dep_valid same cycle in IDLE -> deposit write first, then sweep at (0,0); busy high throughout.
REQ-032 RESET_SIM at 5th sweep cell -> all outputs 0 next cycle, no sweep_done; next start_sweep begins at (0,0).
